// File: rtl/mem_tx_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_tx_pkg                                                        |
// | Brief  : Shared types, default widths and count decode for mem_tx_reader.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mem_tx_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH  = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STAT = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        SEND = 3'd4
    } state_e;

    // A zero word count stands for the full 2**width words.
    function automatic logic [31:0] decode_cnt(input logic [31:0] cnt, input int unsigned width);
        decode_cnt = (cnt == 32'd0) ? (32'd1 << width) : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_tx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mem_tx_reader                                                     |
// | Brief  : Fetches a block of words from the message RAM and streams them to |
// |          the transmit encoder over valid/ready. Optional MEM_TX_STATUS_EN   |
// |          prepends a status word to every block.                            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mem_tx_reader
    import mem_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_cnt,
    input  logic                  abort,
`ifdef MEM_TX_STATUS_EN
    input  logic [DATA_WIDTH-1:0] status_word,
`endif
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_WIDTH:0] C_REM_ONE = (CNT_WIDTH+1)'(1);

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
    logic [CNT_WIDTH:0]    remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                  tx_valid_q,  tx_valid_d;
    logic                  tx_last_q,   tx_last_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  w_handshake;

    assign w_handshake = tx_valid_q && tx_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = (CNT_WIDTH+1)'(decode_cnt(32'(word_cnt), CNT_WIDTH));
`ifdef MEM_TX_STATUS_EN
                    tx_data_d   = status_word;
                    tx_valid_d  = 1'b1;
                    tx_last_d   = 1'b0;
                    state_d     = STAT;
`else
                    state_d     = RD;
`endif
                end
            end
            STAT: begin
                if (w_handshake) begin
                    tx_valid_d = 1'b0;
                    state_d    = RD;
                end
            end
            // Address is already on the RAM; its registered q appears next cycle.
            RD: state_d = CAP;
            CAP: begin
                tx_data_d  = q;
                tx_valid_d = 1'b1;
                tx_last_d  = (remaining_q == C_REM_ONE);
                state_d    = SEND;
            end
            SEND: begin
                if (w_handshake) begin
                    tx_valid_d  = 1'b0;
                    tx_last_d   = 1'b0;
                    remaining_d = remaining_q - C_REM_ONE;
                    if (remaining_q == C_REM_ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any start or handshake seen in the same cycle.
        if (abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rdaddress = ptr_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_tx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mem_tx_reader                                                  |
// | Brief  : Self-checking bench for mem_tx_reader with a registered-read RAM. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mem_tx_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [4:0]  word_cnt = '0;
    logic        abort = 1'b0;
    logic [4:0]  rdaddress;
    logic [15:0] q = '0;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;
    logic        busy;
    logic        done;
`ifdef MEM_TX_STATUS_EN
    logic [15:0] status_word = '0;
`endif

    logic [15:0] ram [32];

    int n_checks = 0;
    int n_fail   = 0;

    mem_tx_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .abort     (abort),
`ifdef MEM_TX_STATUS_EN
        .status_word (status_word),
`endif
        .rdaddress (rdaddress),
        .q         (q),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Dual-port message RAM read side: one cycle registered latency.
    always @(posedge clk) q <= ram[rdaddress];

    // Observations from one transfer
    logic [15:0] obs_data[$];
    logic        obs_last[$];
    logic [4:0]  obs_addr[$];
    int          hs_cyc[$];
    int          rise_cyc[$];
    int          cyc_first_valid, cyc_done, done_count, abort_cyc;
    bit          timed_out, hold_err, post_abort_valid, post_abort_busy;

    // Reference model of the expected word stream
    logic [15:0] exp_data[$];
    logic        exp_last[$];
    logic [4:0]  exp_addr[$];
    logic [15:0] status_val = 16'h0000;

    task automatic build_model(input logic [4:0] b, input logic [4:0] c);
        int n;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        n = (c == 5'd0) ? 32 : int'(c);
`ifdef MEM_TX_STATUS_EN
        exp_data.push_back(status_val); exp_last.push_back(1'b0); exp_addr.push_back(b);
`endif
        for (int i = 0; i < n; i++) begin
            int a;
            a = (int'(b) + i) % 32;
            exp_data.push_back(ram[a]);
            exp_last.push_back(i == n - 1);
            exp_addr.push_back(5'(a));
        end
    endtask

    function automatic int status_words();
`ifdef MEM_TX_STATUS_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Runs one transfer and records what the DUT produced; performs no checks.
    task automatic collect(input logic [4:0] b, input logic [4:0] c, input bit rdy_rand,
                           input int stall_word, input int stall_len, input int abort_word,
                           input bit spurious);
        int   stall_left, tail;
        bit   prev_valid, prev_stalled, aborted, ended;
        logic [16:0] held;
        obs_data.delete(); obs_last.delete(); obs_addr.delete();
        hs_cyc.delete(); rise_cyc.delete();
        cyc_first_valid = -1; cyc_done = -1; done_count = 0; abort_cyc = -1;
        timed_out = 0; hold_err = 0; post_abort_valid = 0; post_abort_busy = 0;
        stall_left = stall_len; tail = -1; held = '0;
        prev_valid = 0; prev_stalled = 0; aborted = 0; ended = 0;
        @(posedge clk); #1;
`ifdef MEM_TX_STATUS_EN
        status_word = status_val;
`endif
        base_addr = b; word_cnt = c; start = 1'b1; abort = 1'b0; tx_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
            @(negedge clk);
            if (tx_valid && !prev_valid) begin
                rise_cyc.push_back(cyc);
                if (cyc_first_valid < 0) cyc_first_valid = cyc;
            end
            prev_valid = tx_valid;
            if (done) begin done_count++; cyc_done = cyc; end
            if (aborted && cyc == abort_cyc + 1) begin
                post_abort_valid = tx_valid; post_abort_busy = busy;
            end
            if (tx_valid) begin
                if (prev_stalled && {tx_last, tx_data} !== held) hold_err = 1;
                held = {tx_last, tx_data};
                prev_stalled = !tx_ready;
            end else begin
                prev_stalled = 0;
            end
            if (tx_valid && tx_ready && !abort) begin
                obs_data.push_back(tx_data); obs_last.push_back(tx_last);
                obs_addr.push_back(rdaddress); hs_cyc.push_back(cyc);
            end
            if (tail < 0 && cyc > 0 && !busy && !tx_valid) tail = cyc;
            if (tail >= 0 && cyc >= tail + 4) ended = 1;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            tx_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
            if (stall_left > 0 && tx_valid && obs_data.size() == stall_word) begin
                tx_ready = 1'b0;
                stall_left--;
                if (spurious) begin
                    start = 1'b1; base_addr = 5'($urandom); word_cnt = 5'($urandom);
                end
            end
            if (abort_word >= 0 && !aborted && tx_valid && obs_data.size() == abort_word) begin
                abort = 1'b1; aborted = 1; abort_cyc = cyc + 1;
            end
        end
        if (!ended) timed_out = 1;
        start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rdaddress !== 5'd0) begin n_fail++; $display("FAIL reset_rdaddress got=%0h exp=0", rdaddress); end
        n_checks++; if (tx_data !== 16'd0) begin n_fail++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_tx_last got=%b exp=0", tx_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
    endtask

    // Compares the recorded stream against the model; inlined per scenario below via this name prefix.
    task automatic test_basic();
        int last_hs;
        ram[4] = 16'h00A1; ram[5] = 16'h00A2; ram[6] = 16'h00A3;
        build_model(5'd4, 5'd3);
        collect(5'd4, 5'd3, 0, -1, 0, -1, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got=1 exp=0"); end
        n_checks++; if (obs_data.size() !== exp_data.size()) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, obs_data[i], exp_data[i]); end
            n_checks++; if (obs_last[i] !== exp_last[i]) begin n_fail++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, obs_last[i], exp_last[i]); end
        end
        n_checks++; if (cyc_first_valid !== (status_words() != 0 ? 1 : 3)) begin n_fail++; $display("FAIL basic_first_valid got=N+%0d exp=N+%0d", cyc_first_valid, (status_words() != 0 ? 1 : 3)); end
        for (int i = 1; i < hs_cyc.size() && i < rise_cyc.size(); i++) begin
            n_checks++; if (rise_cyc[i] !== hs_cyc[i-1] + 3) begin n_fail++; $display("FAIL basic_gap[%0d] got=%0d exp=%0d", i, rise_cyc[i], hs_cyc[i-1] + 3); end
        end
        last_hs = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -100;
        n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_count); end
        n_checks++; if (cyc_done !== last_hs + 1) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", cyc_done, last_hs + 1); end
    endtask

    task automatic test_wrap();
        ram[30] = 16'd1; ram[31] = 16'd2; ram[0] = 16'd3; ram[1] = 16'd4;
        build_model(5'd30, 5'd4);
        collect(5'd30, 5'd4, 1, -1, 0, -1, 0);
        n_checks++; if (obs_data.size() !== exp_data.size() || timed_out) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d to=%0d", obs_data.size(), exp_data.size(), timed_out); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], exp_addr[i]); end
            n_checks++; if (obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, obs_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_full_block();
        logic [4:0] b;
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
        b = 5'($urandom);
        build_model(b, 5'd0);
        collect(b, 5'd0, 1, -1, 0, -1, 0);
        n_checks++; if (obs_data.size() !== 32 + status_words() || timed_out) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d to=%0d", obs_data.size(), 32 + status_words(), timed_out); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i] || obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i])
            begin n_fail++; $display("FAIL full_word[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, obs_data[i], obs_addr[i], obs_last[i], exp_data[i], exp_addr[i], exp_last[i]); end
        end
        n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL full_done_count got=%0d exp=1", done_count); end
    endtask

    task automatic test_stall();
        logic [4:0] b;
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
        b = 5'($urandom);
        build_model(b, 5'd4);
        collect(b, 5'd4, 0, 1 + status_words(), 5, -1, 1);
        n_checks++; if (hold_err) begin n_fail++; $display("FAIL stall_hold got=changed exp=stable"); end
        n_checks++; if (obs_data.size() !== exp_data.size() || timed_out) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d to=%0d", obs_data.size(), exp_data.size(), timed_out); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin n_fail++; $display("FAIL stall_word[%0d] got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]); end
        end
        n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL stall_done_count got=%0d exp=1", done_count); end
    endtask

    task automatic test_abort();
        logic [4:0] b;
        int         k;
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
        b = 5'($urandom);
        k = 1 + status_words();
        build_model(b, 5'd4);
        collect(b, 5'd4, 0, -1, 0, k, 0);
        n_checks++; if (obs_data.size() !== k || timed_out) begin n_fail++; $display("FAIL abort_count got=%0d exp=%0d to=%0d", obs_data.size(), k, timed_out); end
        n_checks++; if (post_abort_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b exp=0", post_abort_valid); end
        n_checks++; if (post_abort_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", post_abort_busy); end
        n_checks++; if (done_count !== 0) begin n_fail++; $display("FAIL abort_done got=%0d exp=0", done_count); end
        for (int i = 0; i < obs_data.size() && i < k; i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL abort_data[%0d] got=%h exp=%h", i, obs_data[i], exp_data[i]); end
        end
        b = 5'($urandom);
        build_model(b, 5'd3);
        collect(b, 5'd3, 0, -1, 0, -1, 0);
        n_checks++; if (obs_data.size() !== exp_data.size() || done_count !== 1 || timed_out) begin n_fail++; $display("FAIL abort_restart got=%0d words/%0d done exp=%0d words/1 done", obs_data.size(), done_count, exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin n_fail++; $display("FAIL abort_restart_word[%0d] got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(posedge clk); #1;
        base_addr = 5'd8; word_cnt = 5'd6; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({tx_valid, tx_last, busy, done} !== 4'b0000 || tx_data !== 16'd0 || rdaddress !== 5'd0)
        begin n_fail++; $display("FAIL reset_mid_state got=v%b l%b b%b d%b data=%h addr=%0d exp=all zero", tx_valid, tx_last, busy, done, tx_data, rdaddress); end
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL reset_mid_idle got=activity exp=idle"); end
    endtask

    task automatic test_random();
        logic [4:0] b, c;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
            status_val = 16'($urandom);
            b = 5'($urandom);
            c = 5'($urandom);
            build_model(b, c);
            collect(b, c, 1, -1, 0, -1, 0);
            n_checks++; if (obs_data.size() !== exp_data.size() || done_count !== 1 || timed_out) begin n_fail++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d/1", t, obs_data.size(), done_count, exp_data.size()); end
            for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
                n_checks++; if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] || obs_addr[i] !== exp_addr[i])
                begin n_fail++; $display("FAIL rand%0d_word[%0d] got=%h/%b/%0d exp=%h/%b/%0d", t, i, obs_data[i], obs_last[i], obs_addr[i], exp_data[i], exp_last[i], exp_addr[i]); end
            end
        end
        status_val = 16'h0000;
    endtask

`ifdef MEM_TX_STATUS_EN
    task automatic test_status();
        for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
        status_val = 16'h0800;
        build_model(5'd12, 5'd2);
        collect(5'd12, 5'd2, 0, -1, 0, -1, 0);
        n_checks++; if (cyc_first_valid !== 1) begin n_fail++; $display("FAIL status_first_valid got=N+%0d exp=N+1", cyc_first_valid); end
        n_checks++; if (obs_data.size() !== 3 || timed_out) begin n_fail++; $display("FAIL status_count got=%0d exp=3", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin n_fail++; $display("FAIL status_word[%0d] got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]); end
        end
        status_val = 16'h0000;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 16'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_full_block();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef MEM_TX_STATUS_EN
        test_status();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
